// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types and helpers for the sequenced 8x8 multiplier.
// Optional feature macro: MULT_SEQ_ZERO_SKIP_EN (zero-nibble state skipping).
package mult_seq_pkg;

  localparam int NIBBLE_W = 4;
  localparam int PP_W     = 8;
  localparam int RES_W    = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    LH   = 3'd2,
    HL   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Bit i set means partial-product state i must run (0=LL, 1=LH, 2=HL, 3=HH).
  function automatic logic [3:0] pp_run_mask(input logic [7:0] a, input logic [7:0] b);
    logic al_nz, ah_nz, bl_nz, bh_nz;
    al_nz = (a[3:0] != 4'd0);
    ah_nz = (a[7:4] != 4'd0);
    bl_nz = (b[3:0] != 4'd0);
    bh_nz = (b[7:4] != 4'd0);
    return {ah_nz & bh_nz, ah_nz & bl_nz, al_nz & bh_nz, al_nz & bl_nz};
  endfunction

  // First state after cur (in the fixed LL->LH->HL->HH order) whose run bit is set, else DONE.
  function automatic state_t next_pp_state(input state_t cur, input logic [3:0] run);
    state_t nxt;
    int     cur_idx;
    case (cur)
      LL:      cur_idx = 0;
      LH:      cur_idx = 1;
      HL:      cur_idx = 2;
      HH:      cur_idx = 3;
      default: cur_idx = -1;
    endcase
    nxt = DONE;
    if (run[3] && (cur_idx < 3)) nxt = HH;
    if (run[2] && (cur_idx < 2)) nxt = HL;
    if (run[1] && (cur_idx < 1)) nxt = LH;
    if (run[0] && (cur_idx < 0)) nxt = LL;
    return nxt;
  endfunction

  // Exact recombination: the cross terms are summed at 9 bits so no carry is lost.
  function automatic logic [RES_W-1:0] combine_pp(input logic [PP_W-1:0] pp_ll,
                                                  input logic [PP_W-1:0] pp_lh,
                                                  input logic [PP_W-1:0] pp_hl,
                                                  input logic [PP_W-1:0] pp_hh);
    logic [PP_W:0] mid;
    mid = {1'b0, pp_lh} + {1'b0, pp_hl};
    return {8'd0, pp_ll} + {3'd0, mid, 4'd0} + {pp_hh, 8'd0};
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshake bundle for mult8_seq_ctrl.
// Handshake rule: a transfer happens on a rising clock edge where both valid
// and ready are high; ready never depends combinationally on valid.
interface mult8_seq_ctrl_if;
  import mult_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        a;
  logic [7:0]        b;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  result;
  logic              busy;
  state_t            state_dbg;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy, state_dbg
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy, state_dbg
  );

endinterface

// File: rtl/mult8_seq_ctrl_mult4x4.sv
// Combinational unsigned 4x4 -> 8 multiplier shared by all partial-product states.
module mult4x4
  import mult_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  output logic [PP_W-1:0]     p
);

  assign p = {4'd0, x} * {4'd0, y};

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequenced 8x8 unsigned multiplier: one 4x4 multiplier reused over the
// LL, LH, HL, HH states, then recombined into a 16-bit product.
// Optional feature macro: MULT_SEQ_ZERO_SKIP_EN skips partial products whose
// nibble pair contains a zero (and goes straight to DONE for a zero operand).
module mult8_seq_ctrl
  import mult_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mult8_seq_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [PP_W-1:0]    pp_ll_q, pp_ll_d;
  logic [PP_W-1:0]    pp_lh_q, pp_lh_d;
  logic [PP_W-1:0]    pp_hl_q, pp_hl_d;
  logic [PP_W-1:0]    pp_hh_q, pp_hh_d;
  logic [3:0]         run_q, run_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [NIBBLE_W-1:0] mul_x, mul_y;
  logic [PP_W-1:0]     mul_p;
  logic [3:0]          run_new;

  // Route the nibble pair selected by the current state into the shared multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      LL:      begin mul_x = a_q[3:0]; mul_y = b_q[3:0]; end
      LH:      begin mul_x = a_q[3:0]; mul_y = b_q[7:4]; end
      HL:      begin mul_x = a_q[7:4]; mul_y = b_q[3:0]; end
      HH:      begin mul_x = a_q[7:4]; mul_y = b_q[7:4]; end
      default: begin mul_x = '0;       mul_y = '0;       end
    endcase
  end

  mult4x4 u_mult4x4 (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  // Next-state, operand capture, partial-product capture and result recombination.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    pp_ll_d     = pp_ll_q;
    pp_lh_d     = pp_lh_q;
    pp_hl_d     = pp_hl_q;
    pp_hh_d     = pp_hh_q;
    run_d       = run_q;
    result_d    = result_q;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    run_new     = pp_run_mask(bus.a, bus.b);
`else
    run_new     = 4'b1111;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          // Clearing every pp here leaves skipped products at zero.
          pp_ll_d = '0;
          pp_lh_d = '0;
          pp_hl_d = '0;
          pp_hh_d = '0;
          run_d   = run_new;
          state_d = next_pp_state(IDLE, run_new);
          if (state_d == DONE) result_d = '0;
        end
      end
      LL, LH, HL, HH: begin
        case (state_q)
          LL:      pp_ll_d = mul_p;
          LH:      pp_lh_d = mul_p;
          HL:      pp_hl_d = mul_p;
          default: pp_hh_d = mul_p;
        endcase
        state_d = next_pp_state(state_q, run_q);
        if (state_d == DONE) result_d = combine_pp(pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d);
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they track state_q exactly.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Single state register for the FSM and its datapath; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      pp_ll_q     <= '0;
      pp_lh_q     <= '0;
      pp_hl_q     <= '0;
      pp_hh_q     <= '0;
      run_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pp_ll_q     <= pp_ll_d;
      pp_lh_q     <= pp_lh_d;
      pp_hl_q     <= pp_hl_d;
      pp_hh_q     <= pp_hh_d;
      run_q       <= run_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed testbench for mult8_seq_ctrl (default build or MULT_SEQ_ZERO_SKIP_EN).
module tb_mult8_seq_ctrl;
  import mult_seq_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  logic [15:0] exp_q[$];

  mult8_seq_ctrl_if bus ();

  mult8_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 5;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    n = 1;
    if (a[3:0] != 0 && b[3:0] != 0) n = n + 1;
    if (a[3:0] != 0 && b[7:4] != 0) n = n + 1;
    if (a[7:4] != 0 && b[3:0] != 0) n = n + 1;
    if (a[7:4] != 0 && b[7:4] != 0) n = n + 1;
`endif
    return n;
  endfunction

  function automatic logic [7:0] rand_opnd();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 4))
      0: v = v & 8'hF0;
      1: v = v & 8'h0F;
      2: v = (v[0]) ? 8'h00 : v;
      default: ;
    endcase
    return v;
  endfunction

  // Driver: present one operand pair from IDLE and wait (bounded) for out_valid.
  // Entered and left just after a falling edge.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_res);
    int n;
    chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom_range(0, 255));
    bus.b = 8'($urandom_range(0, 255));
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_in_ready_busy"}, bus.in_ready, 0);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    chk({tag, "_latency"}, n, exp_lat(a, b));
    chk({tag, "_result"}, bus.result, exp_res);
  endtask

  // Scoreboard step: compare a result as it is handed off.
  task automatic sb_out();
    if (bus.out_valid && bus.out_ready) begin
      chk("rand_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rand_result", bus.result, exp_q.pop_front());
    end
  endtask

  initial begin
    int pulses, first_ov, last_ov, ov_seen, acc, outs;
    checks = 0;
    passed = 0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_state", bus.state_dbg, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Basic product, out_ready high: one-cycle out_valid pulse
    bus.out_ready = 1'b1;
    do_op("p12x34", 8'h12, 8'h34, 16'h03A8);
    @(negedge clk);
    chk("p12x34_ov_drop", bus.out_valid, 0);
    chk("p12x34_in_ready_back", bus.in_ready, 1);

    // Back-to-back with in_valid held high: one accept every 6 cycles
    bus.in_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    pulses = 0;
    first_ov = -1;
    last_ov = -1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk("pFFxFF_result", bus.result, 16'hFE01);
        if (first_ov < 0) first_ov = i;
        last_ov = i;
        pulses = pulses + 1;
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_first", first_ov, 5);
    chk("b2b_last", last_ov, 17);
    chk("b2b_idle_after", bus.in_ready, 1);

    // Output stall: result held, new operands ignored while in DONE
    bus.out_ready = 1'b0;
    do_op("pA5x5A", 8'hA5, 8'h5A, 16'h3A02);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'h11;
      bus.b = 8'h22;
      @(negedge clk);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_result", bus.result, 16'h3A02);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_result_kept", bus.result, 16'h3A02);

    // Reset in the middle of an operation
    bus.in_valid = 1'b1;
    bus.a = 8'h80;
    bus.b = 8'h80;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_result", bus.result, 16'h0000);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_state", bus.state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = ov_seen + 1;
    end
    chk("midrst_no_output", ov_seen, 0);
    do_op("p03x07", 8'h03, 8'h07, 16'h0015);
    @(negedge clk);

    // Zero operands and zero nibbles
    do_op("p00xAB", 8'h00, 8'hAB, 16'h0000);
    @(negedge clk);
    do_op("p0Fx F0", 8'h0F, 8'hF0, 16'h0E10);
    @(negedge clk);
    do_op("pF0x0F", 8'hF0, 8'h0F, 16'h0E10);
    @(negedge clk);
    do_op("p0Dx00", 8'h0D, 8'h00, 16'h0000);
    @(negedge clk);

    // Random sweep against the a*b reference, random valid/ready
    acc = 0;
    outs = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.a         = rand_opnd();
      bus.b         = rand_opnd();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({8'd0, bus.a} * {8'd0, bus.b});
        acc = acc + 1;
      end
      if (bus.out_valid && bus.out_ready) outs = outs + 1;
      sb_out();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) outs = outs + 1;
      sb_out();
    end
    chk("rand_count_match", outs, acc);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_enough_ops", (acc > 20), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
